mux_sweep_driver: RTL and testbench

- Sequential stimulus driver and checker placed directly upstream of the 2:1 CMOS mux (ports a, b, s in; y out).
- On start, it walks all 8 input combinations in the same order the mux bench uses: a toggles fastest, then b, then s.
- Each vector is held for a programmable settle window. y is sampled and compared against the golden 2:1 function, with s=0 selecting a and s=1 selecting b.
- Produces per-vector fail flags, an error count and a pass/done summary, so the mux can be exercised from a clocked harness.

---
 rtl/mux_sweep_pkg.sv | 14 +
 rtl/sweep_hold_timer.sv | 25 ++
 rtl/mux_sweep_driver.sv | 98 +++++++++
 tb/tb_mux_sweep_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sweep_pkg.sv
// Shared types and golden function for the 2:1 mux sweep driver.
package mux_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int ERR_W       = 4;

  function automatic logic exp_mux(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Per-vector settle counter: clear loads 1, enable counts up, term flags HOLD_CYCLES-1.
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam logic [HOLD_W-1:0] TERM_VAL = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= HOLD_W'(1);
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/mux_sweep_driver.sv
// Walks all eight {s,b,a} vectors into a 2:1 mux and scores y against the golden function.
module mux_sweep_driver
  import mux_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECTORS);

  state_t           state, nxt;
  logic [IDX_W-1:0] idx;
  logic             accept, t_clr, t_en, t_term, mismatch;

  sweep_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (t_clr),
    .enable(t_en),
    .term  (t_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    t_clr  = 1'b0;
    t_en   = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        nxt    = DRIVE;
        accept = 1'b1;
        t_clr  = 1'b1;
      end
      DRIVE: begin
        t_en = 1'b1;
        if (t_term) nxt = SAMPLE;
      end
      SAMPLE: begin
        t_clr = 1'b1;
        nxt   = (idx == LAST_IDX) ? DONE : DRIVE;
      end
      default: nxt = IDLE;
    endcase
  end

  // a/b/s always mirror idx, so the comparison can use the driven pins directly
  assign mismatch = (state == SAMPLE) && (y != exp_mux(a, b, s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      {s, b, a} <= 3'b000;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (accept) begin
      idx       <= '0;
      {s, b, a} <= 3'b000;
      err_count <= '0;
      fail_vec  <= '0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        fail_vec[idx] <= 1'b1;
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
      end
      if (idx != LAST_IDX) begin
        idx       <= idx + 1'b1;
        {s, b, a} <= idx + 1'b1;
      end
    end
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_mux_sweep_driver.sv
// Bench for mux_sweep_driver: two instances (hold 4 and hold 2) against a cycle-count model.
module tb_mux_sweep_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st [2];
  int         mode [2];
  logic       yv [2];
  logic       av [2], bv [2], sv [2], bsy [2], dn [2], ps [2];
  logic [3:0] ec [2];
  logic [7:0] fv [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Environment mux: 0 = ideal, 1 = y stuck at 0, 2 = select polarity inverted
  function automatic logic env_y(input int m, input logic a, input logic b, input logic s);
    case (m)
      0:       return s ? b : a;
      1:       return 1'b0;
      default: return s ? a : b;
    endcase
  endfunction

  assign yv[0] = env_y(mode[0], av[0], bv[0], sv[0]);
  assign yv[1] = env_y(mode[1], av[1], bv[1], sv[1]);

  mux_sweep_driver #(.HOLD_CYCLES(4), .HOLD_W(8)) u_h4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .y(yv[0]),
    .a(av[0]), .b(bv[0]), .s(sv[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(ec[0]), .fail_vec(fv[0])
  );

  mux_sweep_driver #(.HOLD_CYCLES(2), .HOLD_W(4)) u_h2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .y(yv[1]),
    .a(av[1]), .b(bv[1]), .s(sv[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(ec[1]), .fail_vec(fv[1])
  );

  // ---------------- model: truth tables indexed by vector number ----------------
  localparam logic [7:0] GOLD = 8'hCA;

  function automatic int hold_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] ytab(input int m);
    case (m)
      0:       return 8'hCA;
      1:       return 8'h00;
      default: return 8'hAC;
    endcase
  endfunction

  function automatic logic mis(input int m, input int v);
    logic [7:0] t;
    t = ytab(m) ^ GOLD;
    return t[v];
  endfunction

  function automatic int popc(input logic [7:0] x);
    int c;
    c = 0;
    for (int k = 0; k < 8; k++) c += int'(x[k]);
    return c;
  endfunction

  logic       m_run [2];
  logic       m_done [2];
  int         m_t [2];
  logic [7:0] m_fail [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_t[i]    <= 0;
        m_fail[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_run[i]) begin
          if (st[i]) begin
            m_run[i]  <= 1'b1;
            m_done[i] <= 1'b0;
            m_t[i]    <= 0;
            m_fail[i] <= 8'h00;
          end
        end else begin
          if ((m_t[i] % hold_of(i)) == hold_of(i) - 1 && mis(mode[i], m_t[i] / hold_of(i)))
            m_fail[i][m_t[i] / hold_of(i)] <= 1'b1;
          if (m_t[i] == 8 * hold_of(i) - 1) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[h%0d] @%0t: got 0x%0h expected 0x%0h", nm, hold_of(inst), $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("vec", i, int'({sv[i], bv[i], av[i]}),
            m_run[i] ? (m_t[i] / hold_of(i)) : (m_done[i] ? 7 : 0));
        chk("flags", i, int'({bsy[i], dn[i], ps[i]}),
            int'({m_run[i], m_done[i], m_done[i] && (m_fail[i] == 8'h00)}));
        chk("err_count", i, int'(ec[i]), popc(m_fail[i]));
        chk("fail_vec", i, int'(fv[i]), int'(m_fail[i]));
      end
    end
  end

  // ---------------- directed flow ----------------
  task automatic run_sweep(input int i, input int m, input bit spam, output int n);
    mode[i] = m;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    chk("start_busy", i, int'({bsy[i], dn[i]}), 2);
    chk("start_clear", i, int'({ec[i], fv[i]}), 0);
    chk("start_vec", i, int'({sv[i], bv[i], av[i]}), 0);
    n = 1;
    while (!dn[i] && n < 400) begin
      if (spam && (n % 3 == 0) && n < 8 * hold_of(i) - 2) st[i] = 1'b1;
      @(negedge clk);
      st[i] = 1'b0;
      n++;
    end
    if (!dn[i]) chk("done_timeout", i, 0, 1);
    chk("sweep_len", i, n - 1, 8 * hold_of(i));
  endtask

  initial begin
    int n;
    st[0] = 1'b0; st[1] = 1'b0;
    mode[0] = 0;  mode[1] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_vec", i, int'({sv[i], bv[i], av[i]}), 0);
      chk("rst_flags", i, int'({bsy[i], dn[i], ps[i]}), 0);
      chk("rst_res", i, int'({ec[i], fv[i]}), 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_sweep(0, 0, 1'b0, n);
    chk("ideal_pass", 0, int'(ps[0]), 1);
    chk("ideal_res", 0, int'({ec[0], fv[0]}), 0);
    chk("ideal_last_vec", 0, int'({sv[0], bv[0], av[0]}), 7);

    run_sweep(0, 1, 1'b0, n);
    chk("tie0_fail_vec", 0, int'(fv[0]), 8'hCA);
    chk("tie0_err", 0, int'(ec[0]), 4);
    chk("tie0_pass", 0, int'(ps[0]), 0);
    repeat (3) @(negedge clk);
    chk("done_held", 0, int'({dn[0], fv[0]}), int'({1'b1, 8'hCA}));

    run_sweep(0, 2, 1'b0, n);
    chk("inv_fail_vec", 0, int'(fv[0]), 8'h66);
    chk("inv_err", 0, int'(ec[0]), 4);
    chk("inv_pass", 0, int'(ps[0]), 0);

    run_sweep(0, 0, 1'b1, n);
    chk("spam_pass", 0, int'(ps[0]), 1);

    // reset during vector 5 of a stuck-at-0 sweep
    mode[0] = 1;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (5 * 4) @(negedge clk);
    chk("pre_rst_vec", 0, int'({sv[0], bv[0], av[0]}), 5);
    chk("pre_rst_fail", 0, int'(fv[0]), 8'h0A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", 0, int'({sv[0], bv[0], av[0]}), 0);
    chk("arst_busy", 0, int'(bsy[0]), 0);
    chk("arst_fail", 0, int'({ec[0], fv[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_after_rst", 0, int'({bsy[0], dn[0], sv[0], bv[0], av[0]}), 0);

    run_sweep(0, 0, 1'b0, n);
    chk("post_rst_pass", 0, int'(ps[0]), 1);

    run_sweep(1, 0, 1'b0, n);
    chk("h2_pass", 1, int'(ps[1]), 1);
    run_sweep(1, 2, 1'b0, n);
    chk("h2_inv_fail_vec", 1, int'(fv[1]), 8'h66);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
